motor_ramp_ctrl: RTL and testbench
==================================

// Module: motor_ramp_ctrl
// PURPOSE
//   Soft-start / direction-reversal controller for the 3-pin PWM motor drive.
//   Turns the 3-bit switch command into a ramped PWM duty and H-bridge direction pins.
//   Direction reversal always ramps down to zero and waits a dead time before driving the other way.
//   Sits between the board switches and the motor driver pins.
// PARAMETERS
//   CNT_W      8    PWM counter width; PWM period = 2**CNT_W clk cycles
//   RAMP_STEP  16   duty change applied per PWM period while ramping
//   DUTY_FULL  240  target duty when switch[2]=1 (must be < 2**CNT_W)
//   DUTY_HALF  128  target duty when switch[2]=0 (must be < 2**CNT_W)
//   DEAD_CYC   64   clk cycles in the DEAD state (>=1)
// PORTS
//   clk     in   1      system clock
//   rst_n   in   1      asynchronous active-low reset
//   switch  in   3      [0]=run, [1]=dir (0=fwd,1=rev), [2]=full speed; asynchronous to clk
//   motor   out  3      [0]=PWM, [1]=IN1 (fwd), [2]=IN2 (rev); registered
//   busy    out  1      1 whenever state != IDLE
//   state   out  3      current FSM state code, for debug
// BEHAVIOUR
// - Reset: all of the following are cleared asynchronously while rst_n=0:
//   - motor=000, busy=0, state=IDLE
//   - duty=0, PWM counter=0, synchronizer flops=0, cur_dir=0
// - Reset mid-operation: outputs go to 000 immediately, with no clock edge needed.
// - Input sync: switch passes through a 2-FF synchronizer (run_s/dir_s/spd_s); 2-cycle latency.
// - Target duty: tgt = run_s ? (spd_s ? DUTY_FULL : DUTY_HALF) : 0.
//   - In STOP, tgt is forced to 0.
// - PWM counter: free-runs 0..2**CNT_W-1 and wraps to 0.
//   - Edge where cnt==max is the "period wrap"; duty changes only on that edge (glitch-free).
// - PWM output: motor[0] = (cnt < duty), registered.
//   - duty=0 gives a constant 0; the maximum duty is 2**CNT_W-1.
// - Ramp arithmetic: computed in CNT_W+1 bits.
//   - Going up: duty = min(duty+RAMP_STEP, tgt). Going down: duty = max(duty-RAMP_STEP, tgt).
//   - duty never overshoots tgt and never wraps.
// - Direction pins: in RAMP/HOLD/STOP, motor[2:1] = cur_dir ? 2'b10 : 2'b01.
//   In IDLE/DEAD, motor[2:1] = 2'b00 (coast). 2'b11 is never driven unless the brake feature is on.
// - FSM states (state codes): IDLE=0, RAMP=1, HOLD=2, STOP=3, DEAD=4.
//   - IDLE: when run_s=1, set cur_dir<=dir_s and go to RAMP.
//   - RAMP: step duty at each wrap.
//     - dir_s!=cur_dir and duty>0 -> STOP (takes priority over other transitions).
//     - duty reaches tgt!=0 -> HOLD.
//     - duty reaches 0 with tgt=0 -> IDLE.
//     - If tgt changes mid-ramp, the ramp follows the new tgt (it may reverse direction).
//   - HOLD: dir_s!=cur_dir -> STOP; otherwise tgt!=duty -> RAMP.
//   - STOP: ramp down to 0; when duty=0 -> DEAD.
//     - A dir_s toggle back during STOP does not abort STOP.
//   - DEAD: count DEAD_CYC cycles, then:
//     - run_s=1: cur_dir<=dir_s, go to RAMP.
//     - run_s=0: go to IDLE.
// - Simultaneous events: when run drops and dir flips in the same cycle, the FSM takes STOP.
//   The end result is the same (ramp to 0, then DEAD, then IDLE).
// CONFIGURATION
// - MOTOR_BRAKE_EN defined: DEAD drives motor[2:1]=2'b11 (active brake). IDLE stays 00.
// - MOTOR_BRAKE_EN undefined: DEAD drives motor[2:1]=2'b00 (coast).
// TESTING  (bench parameters: CNT_W=4, RAMP_STEP=4, DUTY_FULL=12, DUTY_HALF=8, DEAD_CYC=4; clk 20ns)
// 1. rst_n=0 with switch=111 -> motor=000, busy=0, state=0. Hold reset 5 cycles; nothing changes.
// 2. Release reset, switch=001 -> state=RAMP 2-3 cycles later, motor[2:1]=01.
//    - duty goes 4 then 8 over the next two wraps, then state=HOLD.
//    - motor[0] is high for 8 of every 16 cycles.
// 3. From HOLD(8), switch=101 -> duty=12 after one wrap, then HOLD; motor[0] high 12/16 cycles.
// 4. From HOLD(12), switch=111 -> STOP; duty goes 8, 4, 0 on successive wraps.
//    - Then DEAD for 4 cycles with motor=000 (motor[2:1]=11 when MOTOR_BRAKE_EN).
//    - Then RAMP with motor[2:1]=10.
// 5. From HOLD, switch=000 -> duty ramps down to 0, then state=IDLE, busy=0, motor=000.
// 6. Drop rst_n asynchronously mid-RAMP (between clk edges) -> motor=000 before the next clk edge.
//    After release with switch=001, the ramp restarts from duty 0.

Source files
------------

// File: rtl/motor_ramp_ctrl.sv
// Soft-start / direction-reversal controller: 3-bit switch command -> ramped PWM + H-bridge pins.
// Optional MOTOR_BRAKE_EN: drive both bridge inputs (active brake) during the dead time.
module motor_ramp_ctrl #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned RAMP_STEP = 16,
  parameter int unsigned DUTY_FULL = 240,
  parameter int unsigned DUTY_HALF = 128,
  parameter int unsigned DEAD_CYC  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] switch,
  output logic [2:0] motor,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RAMP = 3'd1,
    HOLD = 3'd2,
    STOP = 3'd3,
    DEAD = 3'd4
  } state_t;

  localparam int unsigned EW = CNT_W + 1;
  localparam int unsigned DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [CNT_W-1:0] FULL_D = CNT_W'(DUTY_FULL);
  localparam logic [CNT_W-1:0] HALF_D = CNT_W'(DUTY_HALF);
  localparam logic [EW-1:0]    STEP_E = EW'(RAMP_STEP);
  localparam logic [DW-1:0]    DEAD_LAST = DW'(DEAD_CYC - 1);

  logic [2:0]       sync1, sync2;
  logic             run_s, dir_s, spd_s;
  state_t           state_q;
  logic             cur_dir;
  logic [CNT_W-1:0] cnt, duty, tgt, duty_nxt;
  logic             wrap;
  logic [DW-1:0]    dead_cnt;
  logic             pwm;
  logic [1:0]       pins;
  logic [EW-1:0]    d_ext, t_ext, up, dn;

  function automatic logic [1:0] pins_for(input state_t st, input logic d);
    logic [1:0] p;
    p = 2'b00;
    case (st)
      RAMP, HOLD, STOP: p = d ? 2'b10 : 2'b01;
`ifdef MOTOR_BRAKE_EN
      DEAD:             p = 2'b11;
`else
      DEAD:             p = 2'b00;
`endif
      default:          p = 2'b00;
    endcase
    return p;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= switch;
      sync2 <= sync1;
    end
  end

  assign run_s = sync2[0];
  assign dir_s = sync2[1];
  assign spd_s = sync2[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + CNT_W'(1);
  end

  assign wrap = (cnt == '1);

  always_comb begin
    tgt = '0;
    if (run_s && state_q != STOP) tgt = spd_s ? FULL_D : HALF_D;
  end

  // One extra bit so the step can neither wrap past zero nor past the top.
  always_comb begin
    d_ext    = {1'b0, duty};
    t_ext    = {1'b0, tgt};
    up       = d_ext + STEP_E;
    dn       = d_ext - STEP_E;
    duty_nxt = duty;
    if (t_ext > d_ext)
      duty_nxt = (up >= t_ext) ? tgt : up[CNT_W-1:0];
    else if (t_ext < d_ext)
      duty_nxt = (d_ext < STEP_E || dn <= t_ext) ? tgt : dn[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm <= 1'b0;
    else        pwm <= (cnt < duty);
  end

  // Bridge pins are registered from the state being entered so they change with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      duty     <= '0;
      cur_dir  <= 1'b0;
      dead_cnt <= '0;
      pins     <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (run_s) begin
            cur_dir <= dir_s;
            state_q <= RAMP;
            pins    <= pins_for(RAMP, dir_s);
          end
        end
        RAMP: begin
          if (dir_s != cur_dir && duty != '0) begin
            state_q <= STOP;
            pins    <= pins_for(STOP, cur_dir);
          end else if (wrap) begin
            duty <= duty_nxt;
            if (duty_nxt == tgt) begin
              if (tgt != '0) begin
                state_q <= HOLD;
                pins    <= pins_for(HOLD, cur_dir);
              end else begin
                state_q <= IDLE;
                pins    <= pins_for(IDLE, cur_dir);
              end
            end
          end
        end
        HOLD: begin
          if (dir_s != cur_dir) begin
            state_q <= STOP;
            pins    <= pins_for(STOP, cur_dir);
          end else if (tgt != duty) begin
            state_q <= RAMP;
            pins    <= pins_for(RAMP, cur_dir);
          end
        end
        STOP: begin
          if (wrap) begin
            duty <= duty_nxt;
            if (duty_nxt == '0) begin
              state_q  <= DEAD;
              dead_cnt <= '0;
              pins     <= pins_for(DEAD, cur_dir);
            end
          end
        end
        DEAD: begin
          if (dead_cnt == DEAD_LAST) begin
            if (run_s) begin
              cur_dir <= dir_s;
              state_q <= RAMP;
              pins    <= pins_for(RAMP, dir_s);
            end else begin
              state_q <= IDLE;
              pins    <= pins_for(IDLE, cur_dir);
            end
          end else begin
            dead_cnt <= dead_cnt + DW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          pins    <= 2'b00;
        end
      endcase
    end
  end

  assign motor = {pins, pwm};
  assign busy  = (state_q != IDLE);
  assign state = state_q;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Scoreboard bench for motor_ramp_ctrl: expected per-PWM-period results are queued with each
// stimulus change and popped as each 16-cycle period is observed on the motor pins.
module tb_motor_ramp_ctrl;

  localparam int S_IDLE = 0, S_RAMP = 1, S_HOLD = 2, S_STOP = 3, S_DEAD = 4;
`ifdef MOTOR_BRAKE_EN
  localparam int DEAD_PINS = 3;
`else
  localparam int DEAD_PINS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] switch = 3'b111;
  logic [2:0] motor, state;
  logic       busy;
  int         checks = 0, failures = 0;
  int         cyc = 0;

  // v0/v1/v2: PWM-high count, state, direction pins (reset rows: motor, state, busy)
  typedef struct {
    string tag;
    int    v0;
    int    v1;
    int    v2;
  } exp_t;
  exp_t exp_q[$];

  motor_ramp_ctrl #(
    .CNT_W(4), .RAMP_STEP(4), .DUTY_FULL(12), .DUTY_HALF(8), .DEAD_CYC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .switch(switch),
    .motor(motor), .busy(busy), .state(state)
  );

  always #10 clk = ~clk;

  // Mirrors the PWM counter phase: counts edges since reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic period(output int hi, output int st, output int pins);
    int n;
    n = 0;
    hi = 0;
    @(negedge clk);
    while ((cyc % 16) != 1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL align: cyc=%0d never reached a period start", cyc);
    end
    hi = int'(motor[0]);
    repeat (15) begin
      @(negedge clk);
      hi += int'(motor[0]);
    end
    st = int'(state);
    pins = int'(motor[2:1]);
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    switch = 3'b111;
    for (int i = 0; i < 6; i++) exp_q.push_back('{"reset", 0, S_IDLE, 0});
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (motor !== 3'(e.v0) || state !== 3'(e.v1) || busy !== 1'(e.v2)) begin
        failures++;
        $display("FAIL %s[%0d]: got motor=%b state=%0d busy=%b, expected motor=%0d state=%0d busy=%0d",
                 e.tag, i, motor, state, busy, e.v0, e.v1, e.v2);
      end
    end
  endtask

  task automatic test_soft_start();
    int hi, st, pins;
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1;
    switch = 3'b001;
    exp_q.push_back('{"soft_start p0", 0, S_RAMP, 1});
    exp_q.push_back('{"soft_start p1", 4, S_HOLD, 1});
    exp_q.push_back('{"soft_start p2", 8, S_HOLD, 1});
    repeat (3) begin
      period(hi, st, pins);
      e = exp_q.pop_front();
      checks++;
      if (hi !== e.v0 || st !== e.v1 || pins !== e.v2) begin
        failures++;
        $display("FAIL %s: got hi=%0d state=%0d pins=%0d, expected hi=%0d state=%0d pins=%0d",
                 e.tag, hi, st, pins, e.v0, e.v1, e.v2);
      end
    end
  endtask

  task automatic test_speed_up();
    int hi, st, pins;
    exp_t e;
    switch = 3'b101;
    exp_q.push_back('{"speed_up p0", 8, S_HOLD, 1});
    exp_q.push_back('{"speed_up p1", 12, S_HOLD, 1});
    repeat (2) begin
      period(hi, st, pins);
      e = exp_q.pop_front();
      checks++;
      if (hi !== e.v0 || st !== e.v1 || pins !== e.v2) begin
        failures++;
        $display("FAIL %s: got hi=%0d state=%0d pins=%0d, expected hi=%0d state=%0d pins=%0d",
                 e.tag, hi, st, pins, e.v0, e.v1, e.v2);
      end
    end
  endtask

  task automatic test_reversal();
    int hi, st, pins;
    exp_t e;
    switch = 3'b111;
    exp_q.push_back('{"reversal p0", 12, S_STOP, 1});
    exp_q.push_back('{"reversal p1", 8, S_STOP, 1});
    exp_q.push_back('{"reversal p2", 4, S_DEAD, DEAD_PINS});
    repeat (3) begin
      period(hi, st, pins);
      e = exp_q.pop_front();
      checks++;
      if (hi !== e.v0 || st !== e.v1 || pins !== e.v2) begin
        failures++;
        $display("FAIL %s: got hi=%0d state=%0d pins=%0d, expected hi=%0d state=%0d pins=%0d",
                 e.tag, hi, st, pins, e.v0, e.v1, e.v2);
      end
    end
    // Cycle-level view of the dead time: 4 DEAD samples counting the wrap sample above.
    for (int s = 1; s <= 3; s++) exp_q.push_back('{"dead_cycle", 0, S_DEAD, DEAD_PINS});
    for (int s = 4; s <= 5; s++) exp_q.push_back('{"dead_exit", 0, S_RAMP, 2});
    hi = 0;
    for (int s = 1; s <= 16; s++) begin
      @(negedge clk);
      hi += int'(motor[0]);
      if (s <= 5) begin
        e = exp_q.pop_front();
        checks++;
        if (motor[0] !== 1'b0 || state !== 3'(e.v1) || motor[2:1] !== 2'(e.v2)) begin
          failures++;
          $display("FAIL %s[%0d]: got pwm=%b state=%0d pins=%0d, expected pwm=0 state=%0d pins=%0d",
                   e.tag, s, motor[0], state, motor[2:1], e.v1, e.v2);
        end
      end
    end
    exp_q.push_back('{"reversal p3", 0, S_RAMP, 2});
    exp_q.push_back('{"reversal p4", 4, S_RAMP, 2});
    exp_q.push_back('{"reversal p5", 8, S_HOLD, 2});
    for (int p = 0; p < 3; p++) begin
      if (p > 0) period(hi, st, pins);
      else begin
        st = int'(state);
        pins = int'(motor[2:1]);
      end
      e = exp_q.pop_front();
      checks++;
      if (hi !== e.v0 || st !== e.v1 || pins !== e.v2) begin
        failures++;
        $display("FAIL %s: got hi=%0d state=%0d pins=%0d, expected hi=%0d state=%0d pins=%0d",
                 e.tag, hi, st, pins, e.v0, e.v1, e.v2);
      end
    end
  endtask

  task automatic test_run_stop();
    int hi, st, pins;
    exp_t e;
    switch = 3'b010;
    exp_q.push_back('{"run_stop p0", 12, S_RAMP, 2});
    exp_q.push_back('{"run_stop p1", 8, S_RAMP, 2});
    exp_q.push_back('{"run_stop p2", 4, S_IDLE, 0});
    repeat (3) begin
      period(hi, st, pins);
      e = exp_q.pop_front();
      checks++;
      if (hi !== e.v0 || st !== e.v1 || pins !== e.v2) begin
        failures++;
        $display("FAIL %s: got hi=%0d state=%0d pins=%0d, expected hi=%0d state=%0d pins=%0d",
                 e.tag, hi, st, pins, e.v0, e.v1, e.v2);
      end
    end
    exp_q.push_back('{"run_stop idle", 0, S_IDLE, 0});
    e = exp_q.pop_front();
    checks++;
    if (motor !== 3'(e.v0) || busy !== 1'(e.v2)) begin
      failures++;
      $display("FAIL %s: got motor=%b busy=%b, expected motor=%0d busy=%0d",
               e.tag, motor, busy, e.v0, e.v2);
    end
  endtask

  task automatic test_simultaneous();
    int hi, st, pins;
    exp_t e;
    switch = 3'b001;
    exp_q.push_back('{"simul rise p0", 0, S_RAMP, 1});
    exp_q.push_back('{"simul rise p1", 4, S_HOLD, 1});
    exp_q.push_back('{"simul rise p2", 8, S_HOLD, 1});
    exp_q.push_back('{"simul drop p0", 8, S_STOP, 1});
    exp_q.push_back('{"simul drop p1", 4, S_DEAD, DEAD_PINS});
    exp_q.push_back('{"simul drop p2", 0, S_IDLE, 0});
    for (int p = 0; p < 6; p++) begin
      if (p == 3) switch = 3'b010;
      period(hi, st, pins);
      e = exp_q.pop_front();
      checks++;
      if (hi !== e.v0 || st !== e.v1 || pins !== e.v2) begin
        failures++;
        $display("FAIL %s: got hi=%0d state=%0d pins=%0d, expected hi=%0d state=%0d pins=%0d",
                 e.tag, hi, st, pins, e.v0, e.v1, e.v2);
      end
    end
  endtask

  task automatic test_async_reset();
    int hi, st, pins;
    exp_t e;
    switch = 3'b001;
    exp_q.push_back('{"pre_reset p0", 0, S_RAMP, 1});
    period(hi, st, pins);
    e = exp_q.pop_front();
    checks++;
    if (hi !== e.v0 || st !== e.v1 || pins !== e.v2) begin
      failures++;
      $display("FAIL %s: got hi=%0d state=%0d pins=%0d, expected hi=%0d state=%0d pins=%0d",
               e.tag, hi, st, pins, e.v0, e.v1, e.v2);
    end
    repeat (2) @(negedge clk);
    exp_q.push_back('{"pre_reset motor", 3, S_RAMP, 1});
    e = exp_q.pop_front();
    checks++;
    if (motor !== 3'(e.v0) || state !== 3'(e.v1)) begin
      failures++;
      $display("FAIL %s: got motor=%b state=%0d, expected motor=%0d state=%0d",
               e.tag, motor, state, e.v0, e.v1);
    end
    #3 rst_n = 1'b0;
    exp_q.push_back('{"async_reset", 0, S_IDLE, 0});
    #1;
    e = exp_q.pop_front();
    checks++;
    if (motor !== 3'(e.v0) || state !== 3'(e.v1) || busy !== 1'(e.v2)) begin
      failures++;
      $display("FAIL %s: got motor=%b state=%0d busy=%b, expected motor=%0d state=%0d busy=%0d",
               e.tag, motor, state, busy, e.v0, e.v1, e.v2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back('{"restart p0", 0, S_RAMP, 1});
    exp_q.push_back('{"restart p1", 4, S_HOLD, 1});
    exp_q.push_back('{"restart p2", 8, S_HOLD, 1});
    repeat (3) begin
      period(hi, st, pins);
      e = exp_q.pop_front();
      checks++;
      if (hi !== e.v0 || st !== e.v1 || pins !== e.v2) begin
        failures++;
        $display("FAIL %s: got hi=%0d state=%0d pins=%0d, expected hi=%0d state=%0d pins=%0d",
                 e.tag, hi, st, pins, e.v0, e.v1, e.v2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_soft_start();
    test_speed_up();
    test_reversal();
    test_run_stop();
    test_simultaneous();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
